// File: rtl/display_pkg.sv
// Shared types and default timing constants for the seven-segment scroll controller.
package display_pkg;

    typedef enum logic [1:0] {
        MANUAL     = 2'd0,
        AUTO_STEP  = 2'd1,
        AUTO_DWELL = 2'd2
    } scroll_state_e;

    localparam int COUNT_W = 3;

    localparam int DEF_DEBOUNCE_CYCLES = 500000;
    localparam int DEF_SCROLL_CYCLES   = 25000000;
    localparam int DEF_DWELL_TICKS     = 3;
    localparam int DEF_COUNT_MAX       = 5;

    // Bits needed to hold 0..n-1, never less than one bit.
    function automatic int counter_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Pushbutton conditioning: two-flop synchronizer, stability counter and a
// single-cycle press pulse on the accepted released->pressed transition.
module key_debounce
    import display_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n_i,
    output logic press_o
);

    localparam int CNT_W = counter_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             stable_q;
    logic             stable_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             press_q;
    logic             press_d;
    logic             sync_pressed;
    logic             differ;
    logic             accept;

    assign sync_pressed = ~sync2_q;
    assign differ       = (sync_pressed != stable_q);
    assign accept       = differ && (cnt_q == CNT_LAST);

    // Bring the raw active-low key into the clock domain; idle level is released.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= key_n_i;
            sync2_q <= sync1_q;
        end
    end

    // Count consecutive cycles of disagreement; any bounce back restarts the window.
    always_comb begin
        cnt_d    = cnt_q;
        stable_d = stable_q;
        press_d  = 1'b0;
        if (!differ) begin
            cnt_d = '0;
        end else if (accept) begin
            cnt_d    = '0;
            stable_d = sync_pressed;
            press_d  = sync_pressed;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Debounced level and press pulse registers; reset reports the key released.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            stable_q <= 1'b0;
            press_q  <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
            press_q  <= press_d;
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/display_scroll_ctrl.sv
// Window-select and source-select sequencing for the 6-digit display path,
// with debounced manual keys and an auto-scroll sweep over the 11-digit value.
module display_scroll_ctrl
    import display_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int SCROLL_CYCLES   = DEF_SCROLL_CYCLES,
    parameter int DWELL_TICKS     = DEF_DWELL_TICKS,
    parameter int COUNT_MAX       = DEF_COUNT_MAX
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               key_left_n,
    input  logic               key_right_n,
    input  logic               key_src_n,
    input  logic               auto_en,
    input  logic               result_load,
    output logic [COUNT_W-1:0] count,
    output logic               toggle,
    output logic               auto_active
);

    localparam int TICK_W  = counter_width(SCROLL_CYCLES);
    localparam int DWELL_W = counter_width(DWELL_TICKS);
    localparam logic [TICK_W-1:0]  TICK_LAST  = TICK_W'(SCROLL_CYCLES - 1);
    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL_TICKS - 1);
    localparam logic [COUNT_W-1:0] CMAX       = COUNT_W'(COUNT_MAX);

    logic left_press;
    logic right_press;
    logic src_press;

    scroll_state_e       state_q, state_d;
    logic [COUNT_W-1:0]  count_q, count_d;
    logic                toggle_q, toggle_d;
    logic [TICK_W-1:0]   tick_cnt_q, tick_cnt_d;
    logic [DWELL_W-1:0]  dwell_q, dwell_d;
    logic                auto_en_q;
    logic                auto_active_q;

    logic in_auto;
    logic tick;
    logic auto_rise;

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_left (
        .clk     (clk),
        .rst_n   (rst_n),
        .key_n_i (key_left_n),
        .press_o (left_press)
    );

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_right (
        .clk     (clk),
        .rst_n   (rst_n),
        .key_n_i (key_right_n),
        .press_o (right_press)
    );

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_src (
        .clk     (clk),
        .rst_n   (rst_n),
        .key_n_i (key_src_n),
        .press_o (src_press)
    );

    assign in_auto   = (state_q != MANUAL);
    assign tick      = in_auto && auto_en && (tick_cnt_q == TICK_LAST);
    assign auto_rise = auto_en && !auto_en_q;

    // Next-state logic: result_load beats src, src beats left/right, keys beat the auto tick.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        toggle_d   = toggle_q;
        dwell_d    = dwell_q;
        tick_cnt_d = '0;
        if (in_auto) begin
            tick_cnt_d = (tick_cnt_q == TICK_LAST) ? '0 : tick_cnt_q + 1'b1;
        end

        if (result_load) begin
            toggle_d = 1'b1;
            count_d  = '0;
            if (state_q == AUTO_DWELL) begin
                state_d    = AUTO_STEP;
                tick_cnt_d = '0;
            end
        end else if (src_press) begin
            toggle_d   = ~toggle_q;
            count_d    = '0;
            tick_cnt_d = '0;
        end else if (left_press ^ right_press) begin
            if (right_press) begin
                count_d = (count_q >= CMAX) ? CMAX : count_q + 1'b1;
            end else begin
                count_d = (count_q == '0) ? '0 : count_q - 1'b1;
            end
            state_d = MANUAL;
        end else if (tick) begin
            case (state_q)
                AUTO_STEP: begin
                    if (count_q >= CMAX - 1'b1) begin
                        count_d = CMAX;
                        state_d = AUTO_DWELL;
                        dwell_d = '0;
                    end else begin
                        count_d = count_q + 1'b1;
                    end
                end
                AUTO_DWELL: begin
                    if (dwell_q == DWELL_LAST) begin
                        count_d = '0;
                        state_d = AUTO_STEP;
                    end else begin
                        dwell_d = dwell_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end

        if ((state_q == MANUAL) && auto_rise) begin
            state_d    = AUTO_STEP;
            tick_cnt_d = '0;
        end

        if (in_auto && !auto_en) begin
            state_d = MANUAL;
        end
    end

    // State and output registers; the auto_en copy resets high so a level held through reset is not an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= MANUAL;
            count_q       <= '0;
            toggle_q      <= 1'b0;
            tick_cnt_q    <= '0;
            dwell_q       <= '0;
            auto_en_q     <= 1'b1;
            auto_active_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            count_q       <= count_d;
            toggle_q      <= toggle_d;
            tick_cnt_q    <= tick_cnt_d;
            dwell_q       <= dwell_d;
            auto_en_q     <= auto_en;
            auto_active_q <= (state_d != MANUAL);
        end
    end

    assign count       = count_q;
    assign toggle      = toggle_q;
    assign auto_active = auto_active_q;

endmodule

// File: tb/tb_display_scroll_ctrl.sv
// Directed and randomized checks of the scroll controller against a behavioural model.
module tb_display_scroll_ctrl;

    localparam int D  = 4;
    localparam int S  = 8;
    localparam int DW = 2;
    localparam int CM = 5;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       key_left_n;
    logic       key_right_n;
    logic       key_src_n;
    logic       auto_en;
    logic       result_load;
    logic [2:0] count;
    logic       toggle;
    logic       auto_active;

    int checks = 0;
    int errors = 0;
    int expCount;
    int expToggle;
    int expAuto;

    display_scroll_ctrl #(
        .DEBOUNCE_CYCLES(D),
        .SCROLL_CYCLES  (S),
        .DWELL_TICKS    (DW),
        .COUNT_MAX      (CM)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .key_left_n (key_left_n),
        .key_right_n(key_right_n),
        .key_src_n  (key_src_n),
        .auto_en    (auto_en),
        .result_load(result_load),
        .count      (count),
        .toggle     (toggle),
        .auto_active(auto_active)
    );

    // Free-running 10-unit clock.
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input integer observed, input integer expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic checkAll(input string tag);
        checkOutput({tag, "/count"}, integer'(count), expCount);
        checkOutput({tag, "/toggle"}, integer'(toggle), expToggle);
        checkOutput({tag, "/auto_active"}, integer'(auto_active), expAuto);
    endtask

    // Expected window index m cycles after auto mode starts from window 0.
    function automatic int autoCount(input int m);
        int p;
        p = m % (CM * S + DW * S);
        if (p < CM * S) return p / S;
        return CM;
    endfunction

    // Effect of one accepted key press: 0 left, 1 right, 2 src, 3 left+right together.
    task automatic modelKey(input int key);
        case (key)
            0: begin expCount = (expCount > 0) ? expCount - 1 : 0; expAuto = 0; end
            1: begin expCount = (expCount < CM) ? expCount + 1 : CM; expAuto = 0; end
            2: begin expToggle = 1 - expToggle; expCount = 0; end
            default: ;
        endcase
    endtask

    task automatic setKey(input int key, input logic lvl);
        case (key)
            0: key_left_n = lvl;
            1: key_right_n = lvl;
            2: key_src_n = lvl;
            default: begin key_left_n = lvl; key_right_n = lvl; end
        endcase
    endtask

    // Bounce a key, hold it, release it and let the release settle.
    task automatic applyStimulus(input int key, input int bounces, input int hold);
        for (int b = 0; b < bounces; b++) begin
            setKey(key, 1'b0);
            step($urandom_range(1, 3));
            setKey(key, 1'b1);
            step($urandom_range(1, 3));
        end
        setKey(key, 1'b0);
        step(hold);
        setKey(key, 1'b1);
        step(D + 6);
    endtask

    initial begin
        int n;
        int op;
        rst_n       = 1'b1;
        key_left_n  = 1'b1;
        key_right_n = 1'b1;
        key_src_n   = 1'b1;
        auto_en     = 1'b0;
        result_load = 1'b0;
        expCount    = 0;
        expToggle   = 0;
        expAuto     = 0;

        #2 rst_n = 1'b0;
        step(3);
        checkAll("reset_held");
        rst_n = 1'b1;
        step(2);
        checkAll("reset_released");

        // Bounced right press: three 3-cycle bounces, then a 20-cycle hold.
        for (int b = 0; b < 3; b++) begin
            key_right_n = 1'b0;
            step(3);
            key_right_n = 1'b1;
            step(2);
        end
        key_right_n = 1'b0;
        step(6);
        checkAll("latency_before");
        step(1);
        expCount = 1;
        checkAll("latency_edge");
        step(13);
        checkAll("no_repeat");
        key_right_n = 1'b1;
        step(D + 6);

        // Saturation up and down.
        for (int i = 0; i < 7; i++) begin
            applyStimulus(1, 0, 10);
            modelKey(1);
            checkAll("right_sat");
        end
        for (int i = 0; i < 7; i++) begin
            applyStimulus(0, 0, 10);
            modelKey(0);
            checkAll("left_sat");
        end
        applyStimulus(1, 0, 10);
        modelKey(1);
        checkAll("pre_both");
        applyStimulus(3, 0, 10);
        modelKey(3);
        checkAll("both_ignored");

        // Randomized manual traffic.
        for (int i = 0; i < 16; i++) begin
            op = $urandom_range(0, 4);
            if (op == 4) begin
                result_load = 1'b1;
                step(1);
                result_load = 1'b0;
                step(1);
                expToggle = 1;
                expCount  = 0;
            end else begin
                applyStimulus(op, $urandom_range(0, 2), $urandom_range(8, 15));
                modelKey(op);
            end
            checkAll("random");
        end

        // Return to window 0 on the input-unit source.
        applyStimulus(2, 0, 10);
        modelKey(2);
        if (expToggle == 1) begin
            applyStimulus(2, 0, 10);
            modelKey(2);
        end
        checkAll("pre_auto");

        // Auto sweep from window 0 over two full periods.
        auto_en = 1'b1;
        expAuto = 1;
        n = 0;
        while ((n < 120 || ((n - 1) % 56) != 21) && n < 400) begin
            step(1);
            n++;
            expCount = autoCount(n - 1);
            checkAll("auto_sweep");
        end

        // Manual override landing at window 3.
        key_right_n = 1'b0;
        step(6);
        expCount = 3;
        checkAll("override_before");
        step(1);
        modelKey(1);
        checkAll("override");
        step(5);
        key_right_n = 1'b1;
        step(30);
        checkAll("override_hold");

        // New rising edge resumes from window 4, reaching 5 on the next tick.
        auto_en = 1'b0;
        step(2);
        auto_en = 1'b1;
        step(1);
        expAuto = 1;
        checkAll("resume");
        step(7);
        checkAll("resume_before_tick");
        step(1);
        expCount = 5;
        checkAll("resume_tick");
        auto_en = 1'b0;
        step(1);
        expAuto = 0;
        checkAll("auto_off");
        step(20);
        checkAll("auto_off_hold");

        // result_load coincident with a src press at window 4.
        applyStimulus(0, 0, 10);
        modelKey(0);
        checkAll("pre_load");
        key_src_n = 1'b0;
        step(6);
        result_load = 1'b1;
        step(1);
        result_load = 1'b0;
        expToggle = 1;
        expCount  = 0;
        checkAll("load_wins");
        step(1);
        checkAll("load_after");
        key_src_n = 1'b1;
        step(D + 6);

        // Asynchronous reset in the middle of the dwell.
        auto_en = 1'b1;
        step(1);
        expAuto = 1;
        step(45);
        expCount = 5;
        checkAll("dwell");
        #3 rst_n = 1'b0;
        #1;
        expCount  = 0;
        expToggle = 0;
        expAuto   = 0;
        checkAll("async_reset");
        step(2);
        rst_n = 1'b1;
        step(30);
        checkAll("reset_auto_high");

        // Reset in the middle of a debounce window.
        key_right_n = 1'b0;
        step(4);
        rst_n = 1'b0;
        key_right_n = 1'b1;
        #2 rst_n = 1'b1;
        step(20);
        checkAll("partial_debounce");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
